carryless_divider: RTL

//  Sequential GF(2) polynomial divider; the inverse of the carryless multipliers.

---
 rtl/carryless_pkg.sv | 26 ++
 rtl/leading_one_detector.sv | 26 ++
 rtl/carryless_divider.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/carryless_pkg.sv
// carryless_pkg
//  Shared definitions for the carryless (GF(2) polynomial) arithmetic blocks.
//  - cldiv_state_t : control states of the iterative divider
//  - clmul_ref()   : W x W -> 2W carryless multiply. Benches use it to build
//                    dividends with a known quotient/remainder. Operands are
//                    zero-extended to CL_MAX_W, so any width up to 64 works.
package carryless_pkg;

   localparam int CL_MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      DONE   = 2'd2
   } cldiv_state_t;

   function automatic logic [2*CL_MAX_W-1:0] clmul_ref(input logic [CL_MAX_W-1:0] a,
                                                       input logic [CL_MAX_W-1:0] b);
      logic [2*CL_MAX_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < CL_MAX_W; i++)
         if (b[i]) acc ^= ({{CL_MAX_W{1'b0}}, a} << i);
      return acc;
   endfunction

endpackage

// File: rtl/leading_one_detector.sv
// leading_one_detector
//  Combinational priority encoder: index of the most significant set bit.
//  Ports:
//   data_i  [DATA_WIDTH]          input vector
//   index_o [$clog2(DATA_WIDTH)]  position of the highest 1 (0 when data_i == 0)
//   valid_o                       data_i != 0
module leading_one_detector #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0]         data_i,
   output logic [$clog2(DATA_WIDTH)-1:0] index_o,
   output logic                          valid_o
);

   localparam int IW = $clog2(DATA_WIDTH);

   // Scan upward; the last set bit seen is the most significant one.
   always_comb begin
      index_o = '0;
      for (int i = 0; i < DATA_WIDTH; i++)
         if (data_i[i]) index_o = IW'(i);
   end

   assign valid_o = |data_i;

endmodule

// File: rtl/carryless_divider.sv
// carryless_divider
//  Sequential GF(2) polynomial divider, one quotient bit per cycle.
//  quotient/remainder of dividend / divisor with XOR in place of subtract.
//  Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   data_valid_i       start request, taken only while idle_o = 1
//   dividend_i         dividend polynomial (bit i = coeff of x^i)
//   divisor_i          divisor polynomial; zero flags divide-by-zero
//   quotient_o         result quotient        (held until next result)
//   remainder_o        result remainder       (held until next result)
//   divide_by_zero_o   result came from a zero divisor
//   data_valid_o       one-cycle pulse, results valid
//   idle_o             ready for a new request
//  Latency accept->pulse: DATA_WIDTH+1 cycles, 1 cycle for a zero divisor.
module carryless_divider
   import carryless_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  data_valid_i,
   input  logic [DATA_WIDTH-1:0] dividend_i,
   input  logic [DATA_WIDTH-1:0] divisor_i,
   output logic [DATA_WIDTH-1:0] quotient_o,
   output logic [DATA_WIDTH-1:0] remainder_o,
   output logic                  divide_by_zero_o,
   output logic                  data_valid_o,
   output logic                  idle_o
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);

   cldiv_state_t   state, state_nxt;

   logic [W-1:0]   q_r, r_r, dsr_r;
   logic [CW-1:0]  deg_r, cnt_r;
   logic           dz_r;

   logic [CW-1:0]  lod_idx;
   logic           lod_vld;

   logic           accept, step, finish;

   logic [W-1:0]   rs, r_nxt, q_nxt;
   logic           sub;

   leading_one_detector #(.DATA_WIDTH(W)) u_lod (
      .data_i  (divisor_i),
      .index_o (lod_idx),
      .valid_o (lod_vld)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (data_valid_i) state_nxt = lod_vld ? DIVIDE : DONE;
         DIVIDE:  if (cnt_r == '0)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs / strobes ----------------
   always_comb begin
      idle_o = 1'b0;
      accept = 1'b0;
      step   = 1'b0;
      finish = 1'b0;
      case (state)
         IDLE:    begin idle_o = 1'b1; accept = data_valid_i; end
         DIVIDE:  step   = 1'b1;
         DONE:    finish = 1'b1;
         default: ;
      endcase
   end

   // ---------------- one division step ----------------
   // The next dividend bit enters R from the top of Q. R never has a bit at
   // or above deg, so dropping R[W-1] in the shift loses nothing.
   always_comb begin
      rs    = {r_r[W-2:0], q_r[W-1]};
      sub   = rs[deg_r];
      r_nxt = sub ? (rs ^ dsr_r) : rs;
      q_nxt = {q_r[W-2:0], sub};
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         q_r   <= '0;
         r_r   <= '0;
         dsr_r <= '0;
         deg_r <= '0;
         cnt_r <= '0;
         dz_r  <= 1'b0;
      end else if (accept) begin
         dsr_r <= divisor_i;
         deg_r <= lod_idx;
         cnt_r <= CW'(W-1);
         if (lod_vld) begin
            q_r  <= dividend_i;
            r_r  <= '0;
            dz_r <= 1'b0;
         end else begin
            // zero divisor: all-ones quotient, dividend passes through as remainder
            q_r  <= '1;
            r_r  <= dividend_i;
            dz_r <= 1'b1;
         end
      end else if (step) begin
         q_r <= q_nxt;
         r_r <= r_nxt;
         if (cnt_r != '0) cnt_r <= cnt_r - 1'b1;
      end
   end

   // ---------------- result registers ----------------
   // Only DONE updates these, so they hold the previous result while DIVIDE runs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         quotient_o       <= '0;
         remainder_o      <= '0;
         divide_by_zero_o <= 1'b0;
         data_valid_o     <= 1'b0;
      end else begin
         data_valid_o <= finish;
         if (finish) begin
            quotient_o       <= q_r;
            remainder_o      <= r_r;
            divide_by_zero_o <= dz_r;
         end
      end
   end

endmodule
